// File: rtl/chk_frame_pkg.sv
// Shared constants, types and the check-word function for the frame decoder.
//   DATA_W / CHK_W : data and check bits per frame
//   DEF_CNT_W      : default statistics counter width
//   MASK           : per-check-bit data masks
//   state_e        : decoder FSM states
//   calc_chk       : check word of a data word
package chk_frame_pkg;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned CHK_W     = 4;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned FRAME_W   = DATA_W + CHK_W;
  localparam int unsigned IDX_W     = $clog2(FRAME_W);

  localparam logic [DATA_W-1:0] MASK [CHK_W] = '{12'h0A5, 12'h3C3, 12'h5F0, 12'h90F};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // chk[k] is the parity of the data bits selected by MASK[k]
  function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] data);
    logic [CHK_W-1:0] chk;
    chk = '0;
    for (int k = 0; k < CHK_W; k++) begin
      chk[k] = ^(data & MASK[k]);
    end
    return chk;
  endfunction

endpackage

// File: rtl/chk_frame_decoder_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
//   clk, rst_n : clock, synchronous active-low clear
//   inc_i      : count one event this cycle
//   cnt_o      : current count, sticks at all-ones
module chk_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/chk_frame_decoder.sv
// Deserializes 16-bit frames (12 data + 4 check bits, LSB first), recomputes
// the check word and presents data/syndrome/error over valid/ready, keeping
// saturating frame, error and drop statistics.
//   clk, rst_n             : clock, synchronous active-low reset
//   ser_valid/data/sof     : serial input bit stream, sof marks bit 0
//   out_valid/out_ready    : decoded-frame handshake
//   out_data/out_syndrome  : received data, received^recomputed check
//   out_err                : syndrome is non-zero
//   frame_cnt/err_cnt/drop_cnt : delivered / delivered-with-error / dropped
//   resync                 : sticky, sof seen while mid-frame
module chk_frame_decoder
  import chk_frame_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_valid,
  input  logic              ser_data,
  input  logic              ser_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_syndrome,
  output logic              out_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              resync
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  // Bit 15 is never stored: it is consumed directly on the final capture
  logic [FRAME_W-2:0] frame_q;

  logic              sof_c;
  logic              accept_c;
  logic              last_c;
  logic [DATA_W-1:0] rx_data_c;
  logic [CHK_W-1:0]  rx_chk_c;
  logic [CHK_W-1:0]  syn_c;
  logic              err_inc_c;
  logic              drop_inc_c;

  assign sof_c     = ser_valid & ser_sof;
  assign accept_c  = (state_q == HOLD) & out_valid & out_ready;
  assign last_c    = (idx_q == IDX_W'(FRAME_W - 1));
  assign rx_data_c = frame_q[DATA_W-1:0];
  assign rx_chk_c  = {ser_data, frame_q[FRAME_W-2:DATA_W]};
  assign syn_c     = rx_chk_c ^ calc_chk(rx_data_c);

  assign err_inc_c  = accept_c & out_err;
  // A sof in HOLD is only lost if the held frame is not leaving this cycle
  assign drop_inc_c = (state_q == HOLD) & sof_c & ~accept_c;

  // Frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_q      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_err      <= 1'b0;
      resync       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sof_c) begin
            frame_q[0] <= ser_data;
            idx_q      <= IDX_W'(1);
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (sof_c) begin
            frame_q[0] <= ser_data;
            idx_q      <= IDX_W'(1);
            resync     <= 1'b1;
          end else if (ser_valid) begin
            if (last_c) begin
              out_data     <= rx_data_c;
              out_syndrome <= syn_c;
              out_err      <= |syn_c;
              out_valid    <= 1'b1;
              idx_q        <= '0;
              state_q      <= HOLD;
            end else begin
              frame_q[idx_q] <= ser_data;
              idx_q          <= idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (accept_c) begin
            out_valid <= 1'b0;
            if (sof_c) begin
              frame_q[0] <= ser_data;
              idx_q      <= IDX_W'(1);
              state_q    <= SHIFT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          idx_q     <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  chk_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(accept_c),
    .cnt_o(frame_cnt)
  );

  chk_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(err_inc_c),
    .cnt_o(err_cnt)
  );

  chk_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(drop_inc_c),
    .cnt_o(drop_cnt)
  );

endmodule

// File: tb/tb_chk_frame_decoder.sv
// Directed/self-checking bench for chk_frame_decoder. Inputs change on the
// falling edge and outputs are sampled on the falling edge.
module tb_chk_frame_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_valid, ser_data, ser_sof, out_ready;
  logic        out_valid, out_err, resync;
  logic [11:0] out_data;
  logic [3:0]  out_syndrome;
  logic [15:0] frame_cnt, err_cnt, drop_cnt;
  // Narrow-counter instance sharing all inputs, used to observe saturation
  logic        s_out_valid, s_out_err, s_resync;
  logic [11:0] s_out_data;
  logic [3:0]  s_out_syndrome;
  logic [1:0]  s_frame_cnt, s_err_cnt, s_drop_cnt;

  int n_pass = 0;
  int n_total = 0;
  int exp_frames = 0;
  int exp_errs = 0;
  int exp_drops = 0;

  always #5 clk = ~clk;

  chk_frame_decoder dut (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_sof(ser_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_err(out_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt), .resync(resync)
  );

  chk_frame_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_sof(ser_sof), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_syndrome(s_out_syndrome), .out_err(s_out_err),
    .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt), .drop_cnt(s_drop_cnt), .resync(s_resync)
  );

  // Independent reference for the check word
  function automatic logic [3:0] ref_chk(input logic [11:0] d);
    logic [11:0] m0, m1, m2, m3;
    m0 = 12'h0A5; m1 = 12'h3C3; m2 = 12'h5F0; m3 = 12'h90F;
    return {^(d & m3), ^(d & m2), ^(d & m1), ^(d & m0)};
  endfunction

  // Drive the first nb bits of a frame; optionally a random idle cycle before
  // each bit, and optionally assert out_ready together with bit 0.
  task automatic send_bits(input logic [15:0] f, input int nb, input bit gaps, input bit acc);
    for (int i = 0; i < nb; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        @(negedge clk);
        ser_valid = 1'b0; ser_sof = 1'b0; out_ready = 1'b0;
      end
      @(negedge clk);
      ser_valid = 1'b1;
      ser_data  = f[i];
      ser_sof   = (i == 0);
      out_ready = acc && (i == 0);
    end
  endtask

  task automatic send_frame(input logic [11:0] d, input logic [3:0] c, input bit gaps, input bit acc);
    send_bits({c, d}, 16, gaps, acc);
    @(negedge clk);
    ser_valid = 1'b0; ser_sof = 1'b0; out_ready = 1'b0;
  endtask

  task automatic accept_frame();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ser_valid = 1'b0; ser_data = 1'b0; ser_sof = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 12'h000) $display("FAIL reset_data: got %h want 000", out_data); else n_pass++;
    n_total++; if (out_syndrome !== 4'h0 || out_err !== 1'b0) $display("FAIL reset_syn: got %h/%b want 0/0", out_syndrome, out_err); else n_pass++;
    n_total++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0 || drop_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", frame_cnt, err_cnt, drop_cnt); else n_pass++;
    n_total++; if (resync !== 1'b0) $display("FAIL reset_resync: got %b want 0", resync); else n_pass++;
    rst_n = 1'b1;
    // Bits without sof in IDLE must be ignored
    ser_valid = 1'b1; ser_data = 1'b1;
    repeat (20) @(negedge clk);
    ser_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL idle_nosof: got valid %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_basic();
    send_bits(16'h0000, 15, 1'b0, 1'b0);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid); else n_pass++;
    ser_valid = 1'b1; ser_data = 1'b0; ser_sof = 1'b0;
    @(negedge clk);
    ser_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 12'h000 || out_syndrome !== 4'h0 || out_err !== 1'b0)
      $display("FAIL basic_out: got %h/%h/%b want 000/0/0", out_data, out_syndrome, out_err); else n_pass++;
    accept_frame(); exp_frames++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_drop_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (frame_cnt !== 16'(exp_frames) || err_cnt !== 16'd0)
      $display("FAIL basic_cnt: got %0d/%0d want %0d/0", frame_cnt, err_cnt, exp_frames); else n_pass++;
  endtask

  task automatic test_check();
    send_frame(12'h001, 4'b1011, 1'b0, 1'b0);
    n_total++; if (out_data !== 12'h001 || out_syndrome !== 4'b0000 || out_err !== 1'b0)
      $display("FAIL chk_good: got %h/%b/%b want 001/0000/0", out_data, out_syndrome, out_err); else n_pass++;
    accept_frame(); exp_frames++;
    send_frame(12'h001, 4'b0000, 1'b0, 1'b0);
    n_total++; if (out_syndrome !== 4'b1011 || out_err !== 1'b1)
      $display("FAIL chk_bad: got %b/%b want 1011/1", out_syndrome, out_err); else n_pass++;
    accept_frame(); exp_frames++; exp_errs++;
    n_total++; if (frame_cnt !== 16'(exp_frames) || err_cnt !== 16'(exp_errs))
      $display("FAIL chk_cnt: got %0d/%0d want %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs); else n_pass++;
    n_total++; if (out_data !== 12'h001 || out_syndrome !== 4'b1011)
      $display("FAIL chk_hold_after: got %h/%b want 001/1011", out_data, out_syndrome); else n_pass++;
  endtask

  task automatic test_hold();
    send_frame(12'h123, ref_chk(12'h123), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      n_total++; if (out_valid !== 1'b1 || out_data !== 12'h123 || out_err !== 1'b0)
        $display("FAIL hold_stable%0d: got %b/%h/%b want 1/123/0", c, out_valid, out_data, out_err); else n_pass++;
      @(negedge clk);
      ser_valid = (c == 2); ser_sof = (c == 2); ser_data = 1'b1;
    end
    @(negedge clk);
    ser_valid = 1'b0; ser_sof = 1'b0;
    exp_drops++;
    n_total++; if (drop_cnt !== 16'(exp_drops) || frame_cnt !== 16'(exp_frames))
      $display("FAIL hold_drop: got %0d/%0d want %0d/%0d", drop_cnt, frame_cnt, exp_drops, exp_frames); else n_pass++;
    accept_frame(); exp_frames++;
    repeat (2) @(negedge clk);
    n_total++; if (frame_cnt !== 16'(exp_frames) || out_valid !== 1'b0)
      $display("FAIL hold_accept: got %0d/%b want %0d/0", frame_cnt, out_valid, exp_frames); else n_pass++;
  endtask

  task automatic test_resync();
    send_bits(16'hF555, 7, 1'b0, 1'b0);
    send_frame(12'hABC, ref_chk(12'hABC), 1'b0, 1'b0);
    n_total++; if (resync !== 1'b1) $display("FAIL resync_flag: got %b want 1", resync); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_data !== 12'hABC || out_err !== 1'b0)
      $display("FAIL resync_frame: got %b/%h/%b want 1/abc/0", out_valid, out_data, out_err); else n_pass++;
    accept_frame(); exp_frames++;
  endtask

  task automatic test_random_back_to_back();
    logic [11:0] d;
    logic [3:0]  flip;
    bit          prev_bad;
    prev_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      d    = 12'($urandom);
      flip = ((i % 10) == 3) ? 4'(1 << (i % 4)) : 4'h0;
      // Acceptance of the previous frame coincides with this frame's sof
      send_frame(d, ref_chk(d) ^ flip, 1'b1, i > 0);
      if (i > 0) begin
        exp_frames++;
        if (prev_bad) exp_errs++;
      end
      prev_bad = (flip != 4'h0);
      n_total++; if (out_valid !== 1'b1 || out_data !== d || out_syndrome !== flip || out_err !== prev_bad)
        $display("FAIL rand%0d: got %b/%h/%h/%b want 1/%h/%h/%b", i, out_valid, out_data, out_syndrome, out_err, d, flip, prev_bad);
      else n_pass++;
    end
    accept_frame(); exp_frames++;
    if (prev_bad) exp_errs++;
    n_total++; if (frame_cnt !== 16'(exp_frames) || err_cnt !== 16'(exp_errs))
      $display("FAIL rand_cnt: got %0d/%0d want %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs); else n_pass++;
    n_total++; if (drop_cnt !== 16'(exp_drops)) $display("FAIL rand_nodrop: got %0d want %0d", drop_cnt, exp_drops); else n_pass++;
    n_total++; if (s_frame_cnt !== 2'd3 || s_err_cnt !== 2'd3 || s_drop_cnt !== 2'd1)
      $display("FAIL sat_cnt: got %0d/%0d/%0d want 3/3/1", s_frame_cnt, s_err_cnt, s_drop_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] f;
    f = {ref_chk(12'h3A5), 12'h3A5};
    send_bits(f, 9, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; ser_valid = 1'b1; ser_sof = 1'b0; ser_data = f[9];
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || out_data !== 12'h000 || resync !== 1'b0 || frame_cnt !== 16'd0 || err_cnt !== 16'd0 || drop_cnt !== 16'd0)
      $display("FAIL rstmid: got %b/%h/%b/%0d/%0d/%0d want 0/000/0/0/0/0", out_valid, out_data, resync, frame_cnt, err_cnt, drop_cnt); else n_pass++;
    rst_n = 1'b1; ser_valid = 1'b0;
    send_frame(12'h3A5, ref_chk(12'h3A5), 1'b0, 1'b0);
    n_total++; if (out_valid !== 1'b1 || out_data !== 12'h3A5 || out_err !== 1'b0)
      $display("FAIL rstmid_next: got %b/%h/%b want 1/3a5/0", out_valid, out_data, out_err); else n_pass++;
    // Reset while holding a frame: discarded without counting
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || out_data !== 12'h000 || out_syndrome !== 4'h0 || frame_cnt !== 16'd0)
      $display("FAIL rsthold: got %b/%h/%h/%0d want 0/000/0/0", out_valid, out_data, out_syndrome, frame_cnt); else n_pass++;
    rst_n = 1'b1;
    send_frame(12'h5C7, ref_chk(12'h5C7) ^ 4'h4, 1'b0, 1'b0);
    n_total++; if (out_data !== 12'h5C7 || out_syndrome !== 4'h4 || out_err !== 1'b1)
      $display("FAIL rsthold_next: got %h/%h/%b want 5c7/4/1", out_data, out_syndrome, out_err); else n_pass++;
    accept_frame();
    n_total++; if (frame_cnt !== 16'd1 || err_cnt !== 16'd1)
      $display("FAIL rsthold_cnt: got %0d/%0d want 1/1", frame_cnt, err_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_check();
    test_hold();
    test_resync();
    test_random_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
